// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped, write-through cache controller.
// Holds the FSM state encoding, default geometry and address field positions.
package cache_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int INDEX_W = 10;
  localparam int TAG_W   = ADDR_W - 2 - INDEX_W;

  // cpu_addr field slices: [1:0] byte offset (ignored), then index, then tag
  localparam int IDX_LSB = 2;
  localparam int TAG_LSB = IDX_LSB + INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_MEM_RD = 3'd2,
    S_MEM_WR = 3'd3,
    S_REFILL = 3'd4,
    S_DONE   = 3'd5,
    S_FLUSH  = 3'd6
  } state_t;

endpackage

// File: rtl/tag_data_ram.sv
// Tag + data storage for the cache. One write port, one registered read port.
// Contents are deliberately not reset; validity lives in the external valid RAM.
//   clock        : rising-edge clock
//   we           : write strobe for windex
//   windex/wtag/wdata : write port
//   rindex       : read address, sampled every edge
//   rtag/rdata   : registered read data for the index sampled at the last edge
module tag_data_ram import cache_pkg::*; #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10,
  parameter int TG_W  = 20
) (
  input  logic              clock,
  input  logic              we,
  input  logic [IDX_W-1:0]  windex,
  input  logic [TG_W-1:0]   wtag,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  rindex,
  output logic [TG_W-1:0]   rtag,
  output logic [DATA_W-1:0] rdata
);

  logic [TG_W-1:0]   tag_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      tag_mem[windex]  <= wtag;
      data_mem[windex] <= wdata;
    end
    rtag  <= tag_mem[rindex];
    rdata <= data_mem[rindex];
  end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// Valid bits are in an external RAM (registered read), tags/data in tag_data_ram.
//   clock, reset        : rising-edge clock, async active-high reset
//   cpu_req/we/addr/wdata/flush : CPU request side, sampled only in IDLE
//   cpu_rdata, cpu_ready: one-cycle completion with load data (0 for stores)
//   busy                : high in every state except IDLE
//   mem_*               : single-word memory port, request held until mem_ack
//   v_write/v_in/v_index, v_out : external valid-bit RAM port
module cache_ctrl import cache_pkg::*; #(
  parameter  int CACHESIZE = 1024,
  parameter  int TAG_W     = 30 - $clog2(CACHESIZE),
  localparam int IDX_W     = $clog2(CACHESIZE)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic              cpu_flush,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              v_write,
  output logic              v_in,
  output logic [IDX_W-1:0]  v_index,
  input  logic              v_out
);

  localparam int TLSB = IDX_LSB + IDX_W;

  state_t            state, state_d;
  logic [IDX_W-1:0]  idx_q, fcnt;
  logic [TAG_W-1:0]  tag_q;
  logic              we_q, hit_q;
  logic [31:0]       wdata_q, rdata_q;

  logic [IDX_W-1:0]  cpu_idx, rd_idx;
  logic [TAG_W-1:0]  cpu_tag, rd_tag;
  logic [31:0]       rd_data;
  logic              hit, ram_we;
  logic              unused_addr;

  assign cpu_idx     = cpu_addr[IDX_LSB +: IDX_W];
  assign cpu_tag     = cpu_addr[TLSB +: TAG_W];
  assign unused_addr = ^cpu_addr[1:0];

  // Read address is presented in IDLE so LOOKUP sees the registered result
  // of the same edge that accepted the request; the valid RAM tracks it.
  assign rd_idx  = (state == S_IDLE) ? cpu_idx : idx_q;
  assign v_index = (state == S_FLUSH) ? fcnt : rd_idx;
  assign hit     = v_out && (rd_tag == tag_q);

  tag_data_ram #(.DEPTH(CACHESIZE), .IDX_W(IDX_W), .TG_W(TAG_W)) u_ram (
    .clock  (clock),
    .we     (ram_we),
    .windex (idx_q),
    .wtag   (tag_q),
    .wdata  (we_q ? wdata_q : rdata_q),
    .rindex (rd_idx),
    .rtag   (rd_tag),
    .rdata  (rd_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q   <= '0;
      tag_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      hit_q   <= 1'b0;
      rdata_q <= '0;
      fcnt    <= '0;
    end else begin
      case (state)
        S_IDLE: if (!cpu_flush && cpu_req) begin
          idx_q   <= cpu_idx;
          tag_q   <= cpu_tag;
          we_q    <= cpu_we;
          wdata_q <= cpu_wdata;
        end
        S_LOOKUP: begin
          hit_q <= hit;
          if (hit) rdata_q <= rd_data;
        end
        S_MEM_RD: if (mem_ack) rdata_q <= mem_rdata;
        S_FLUSH:  fcnt <= (fcnt == IDX_W'(CACHESIZE - 1)) ? '0 : fcnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state;
    busy      = (state != S_IDLE);
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    v_write   = 1'b0;
    v_in      = 1'b0;
    ram_we    = 1'b0;
    case (state)
      S_IDLE: begin
        if (cpu_flush)    state_d = S_FLUSH;
        else if (cpu_req) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (we_q)     state_d = S_MEM_WR;
        else if (hit) state_d = S_DONE;
        else          state_d = S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        mem_addr = {tag_q, idx_q, 2'b00};
        if (mem_ack) state_d = S_REFILL;
      end
      S_MEM_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q, idx_q, 2'b00};
        mem_wdata = wdata_q;
        // write-through; only a line already present is updated
        if (mem_ack) state_d = hit_q ? S_REFILL : S_DONE;
      end
      S_REFILL: begin
        ram_we  = 1'b1;
        v_write = 1'b1;
        v_in    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        cpu_ready = 1'b1;
        cpu_rdata = we_q ? '0 : rdata_q;
        state_d   = S_IDLE;
      end
      S_FLUSH: begin
        v_write = 1'b1;
        if (fcnt == IDX_W'(CACHESIZE - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a valid-RAM model, a memory responder
// and a scoreboard of expected cpu_rdata / memory transactions.
module tb_cache_ctrl;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } mem_txn_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_flush;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ready, busy;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        v_write, v_in, v_out;
  logic [9:0]  v_index;

  int errors = 0;
  int checks = 0;
  int mreq_cnt = 0;
  int vw_cnt = 0;
  int vw_idx = -1;
  bit mem_en = 1'b1;
  bit prev_mreq = 1'b0;
  bit vram [1024];

  logic [31:0] exp_rsp [$];
  mem_txn_t    exp_mem [$];

  always #5 clock = ~clock;

  cache_ctrl dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_flush(cpu_flush),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .v_write(v_write), .v_in(v_in), .v_index(v_index), .v_out(v_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // valid-bit RAM: registered read, old data on read-during-write,
  // powers up all-ones so an unflushed cache would falsely hit
  initial for (int i = 0; i < 1024; i++) vram[i] = 1'b1;
  always @(posedge clock) begin
    v_out <= vram[v_index];
    if (v_write) vram[v_index] <= v_in;
  end

  // response monitor
  always @(negedge clock) begin
    if (!reset && cpu_ready) begin
      if (exp_rsp.size() == 0) chk("unexpected_cpu_ready", 32'd1, 32'd0);
      else chk("cpu_rdata", cpu_rdata, exp_rsp.pop_front());
    end
  end

  // event counters: memory request starts and refill valid writes
  always @(negedge clock) begin
    if (mem_req && !prev_mreq) mreq_cnt++;
    prev_mreq = mem_req;
    if (v_write && v_in) begin
      vw_cnt++;
      vw_idx = int'(v_index);
    end
  end

  // memory responder: checks the request, acks two cycles later
  initial begin
    mem_txn_t t;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clock);
      if (mem_req && mem_en && !reset) begin
        if (exp_mem.size() == 0) chk("unexpected_mem_req", mem_addr, 32'hFFFF_FFFF);
        else begin
          t = exp_mem.pop_front();
          chk("mem_we", {31'd0, mem_we}, {31'd0, t.we});
          chk("mem_addr", mem_addr, t.addr);
          if (t.we) chk("mem_wdata", mem_wdata, t.wdata);
          @(posedge clock); @(posedge clock); #1;
          mem_ack = 1'b1; mem_rdata = t.rdata;
          @(posedge clock); #1;
          mem_ack = 1'b0; mem_rdata = '0;
        end
      end
    end
  end

  task automatic push_mem(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd);
    mem_txn_t t;
    t.we = we; t.addr = a; t.wdata = wd; t.rdata = rd;
    exp_mem.push_back(t);
  endtask

  // issue one request from IDLE; lat = negedges after the accepting edge
  task automatic cpu_op(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp, output int lat);
    @(posedge clock); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    exp_rsp.push_back(exp);
    @(posedge clock); #1;
    cpu_req = 1'b0;
    lat = 0;
    while (lat < 200) begin
      @(negedge clock);
      lat++;
      if (cpu_ready) break;
    end
    if (lat >= 200) chk("cpu_ready_timeout", 32'd0, 32'd1);
    @(posedge clock); #1;
  endtask

  initial begin
    int lat, m0, w0, bad;
    reset = 1'b1; cpu_req = 0; cpu_we = 0; cpu_flush = 0;
    cpu_addr = '0; cpu_wdata = '0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_outs", {cpu_ready, mem_req, mem_we, v_write, v_in}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // flush, with a simultaneous cpu_req that must lose and then be ignored
    @(posedge clock); #1;
    cpu_flush = 1'b1; cpu_req = 1'b1; cpu_addr = 32'h0000_1004;
    @(posedge clock); #1;
    cpu_flush = 1'b0;
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clock);
      if (i == 3) cpu_req = 1'b0;
      if (!(v_write === 1'b1 && v_in === 1'b0 && v_index === 10'(i) && busy === 1'b1)) bad++;
    end
    chk("flush_seq_bad_cycles", bad, 0);
    @(negedge clock);
    chk("flush_done_busy", {31'd0, busy}, 32'd0);
    chk("flush_vwrite_off", {31'd0, v_write}, 32'd0);

    // cold read miss
    push_mem(1'b0, 32'h0000_1004, 32'd0, 32'hDEAD_BEEF);
    cpu_op(1'b0, 32'h0000_1004, 32'd0, 32'hDEAD_BEEF, lat);
    chk("refill_count", vw_cnt, 1);
    chk("refill_index", vw_idx, 1);

    // read hit: no memory traffic, two-cycle latency
    m0 = mreq_cnt;
    cpu_op(1'b0, 32'h0000_1006, 32'd0, 32'hDEAD_BEEF, lat);
    chk("hit_latency", lat, 2);
    chk("hit_no_mem_req", mreq_cnt, m0);

    // conflict miss, then original line misses again, then re-fetch 0x2004
    push_mem(1'b0, 32'h0000_2004, 32'd0, 32'hCAFE_F00D);
    cpu_op(1'b0, 32'h0000_2004, 32'd0, 32'hCAFE_F00D, lat);
    push_mem(1'b0, 32'h0000_1004, 32'd0, 32'hDEAD_BEEF);
    cpu_op(1'b0, 32'h0000_1004, 32'd0, 32'hDEAD_BEEF, lat);
    chk("conflict_refills", vw_cnt, 3);
    push_mem(1'b0, 32'h0000_2004, 32'd0, 32'hCAFE_F00D);
    cpu_op(1'b0, 32'h0000_2004, 32'd0, 32'hCAFE_F00D, lat);

    // write hit: write-through then line update
    w0 = vw_cnt;
    push_mem(1'b1, 32'h0000_2004, 32'h1234_5678, 32'd0);
    cpu_op(1'b1, 32'h0000_2004, 32'h1234_5678, 32'd0, lat);
    chk("write_hit_refill", vw_cnt, w0 + 1);
    m0 = mreq_cnt;
    cpu_op(1'b0, 32'h0000_2004, 32'd0, 32'h1234_5678, lat);
    chk("write_hit_readback_lat", lat, 2);
    chk("write_hit_readback_nomem", mreq_cnt, m0);

    // write miss: memory only, no allocate
    w0 = vw_cnt;
    push_mem(1'b1, 32'h0000_3008, 32'hA5A5_0001, 32'd0);
    cpu_op(1'b1, 32'h0000_300A, 32'hA5A5_0001, 32'd0, lat);
    chk("write_miss_no_vwrite", vw_cnt, w0);
    push_mem(1'b0, 32'h0000_3008, 32'd0, 32'h0BAD_F00D);
    cpu_op(1'b0, 32'h0000_3008, 32'd0, 32'h0BAD_F00D, lat);

    // reset in the middle of a memory read
    mem_en = 1'b0;
    @(posedge clock); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_5000;
    @(posedge clock); #1;
    cpu_req = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("mem_rd_pending", {31'd0, mem_req}, 32'd1);
    chk("mem_rd_addr", mem_addr, 32'h0000_5000);
    reset = 1'b1;
    #1;
    chk("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    @(posedge clock); #1;
    mem_ack = 1'b0; mem_rdata = '0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (busy !== 1'b0 || mem_req !== 1'b0 || cpu_ready !== 1'b0) bad++;
    end
    chk("late_ack_ignored", bad, 0);
    mem_en = 1'b1;

    // arrays and valid bits survive reset
    m0 = mreq_cnt;
    cpu_op(1'b0, 32'h0000_2004, 32'd0, 32'h1234_5678, lat);
    chk("post_rst_hit_lat", lat, 2);
    chk("post_rst_hit_nomem", mreq_cnt, m0);

    repeat (3) @(posedge clock);
    chk("rsp_queue_drained", exp_rsp.size(), 0);
    chk("mem_queue_drained", exp_mem.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
